// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state encoding and default register-address width
package hazard_pkg;
    localparam int REG_ADDR_W_DEF = 3;
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_PUSH  = 2'd2,
        ST_JUMP  = 2'd3
    } state_t;
endpackage

// File: rtl/hazard_compare.sv
// hazard_compare: RAW matcher of decode sources against EX and MEM destinations
module hazard_compare #(
    parameter int W = 3
) (
    input  logic [W-1:0] src1_addr,
    input  logic [W-1:0] src2_addr,
    input  logic         src1_used,
    input  logic         src2_used,
    input  logic         ex_en,
    input  logic [W-1:0] ex_addr,
    input  logic         mem_en,
    input  logic [W-1:0] mem_addr,
    output logic         hz
);
    logic ex_hit, mem_hit;
    assign ex_hit  = (src1_used && src1_addr == ex_addr) || (src2_used && src2_addr == ex_addr);
    assign mem_hit = (src1_used && src1_addr == mem_addr) || (src2_used && src2_addr == mem_addr);
    assign hz      = (ex_en && ex_hit) || (mem_en && mem_hit);
endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use stall, branch flush and interrupt entry sequencing.
// Define HAZ_NO_FORWARD_EN to stall on any RAW match against EX or MEM (no forwarding).
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_src1_addr,
    input  logic [REG_ADDR_W-1:0] id_src2_addr,
    input  logic                  id_src1_used,
    input  logic                  id_src2_used,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_wr_addr,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_wr_addr,
    input  logic                  branch_taken,
    input  logic                  int_req,
    output logic                  pc_stall,
    output logic                  ifid_stall,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  int_push,
    output logic                  int_jump,
    output logic                  int_ack,
    output logic [CNT_W-1:0]      stall_count
);
    state_t state, state_n;
    logic [2:0] drain_cnt, drain_n;
    logic int_pending, pend_n;
    logic hz, ex_en, mem_en;
    logic [REG_ADDR_W-1:0] mem_addr;

`ifdef HAZ_NO_FORWARD_EN
    assign ex_en    = ex_reg_write;
    assign mem_en   = mem_reg_write;
    assign mem_addr = mem_wr_addr;
`else
    logic unused_mem;
    assign unused_mem = ^{mem_reg_write, mem_wr_addr};
    assign ex_en      = ex_reg_write && ex_mem_read;
    assign mem_en     = 1'b0;
    assign mem_addr   = '0;
`endif

    hazard_compare #(.W(REG_ADDR_W)) u_cmp (
        .src1_addr(id_src1_addr),
        .src2_addr(id_src2_addr),
        .src1_used(id_src1_used),
        .src2_used(id_src2_used),
        .ex_en(ex_en),
        .ex_addr(ex_wr_addr),
        .mem_en(mem_en),
        .mem_addr(mem_addr),
        .hz(hz)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            drain_cnt   <= '0;
            int_pending <= 1'b0;
            stall_count <= '0;
        end else begin
            state       <= state_n;
            drain_cnt   <= drain_n;
            int_pending <= pend_n;
            if (pc_stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
        end
    end

    // The RUN cycle that accepts an interrupt is the first of DRAIN_CYCLES bubbles.
    always_comb begin
        state_n     = state;
        drain_n     = drain_cnt;
        pend_n      = int_pending || int_req;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        int_push    = 1'b0;
        int_jump    = 1'b0;
        int_ack     = 1'b0;
        case (state)
            ST_RUN: begin
                if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (hz) begin
                    {pc_stall, ifid_stall, idex_bubble} = 3'b111;
                end else if (int_pending || int_req) begin
                    {pc_stall, ifid_stall, idex_bubble} = 3'b111;
                    state_n = (DRAIN_CYCLES == 1) ? ST_PUSH : ST_DRAIN;
                    drain_n = 3'(DRAIN_CYCLES - 1);
                    pend_n  = 1'b0;
                end
            end
            ST_DRAIN: begin
                {pc_stall, ifid_stall, idex_bubble} = 3'b111;
                drain_n = drain_cnt - 3'd1;
                state_n = (drain_cnt == 3'd1) ? ST_PUSH : ST_DRAIN;
            end
            ST_PUSH: begin
                {pc_stall, ifid_stall, idex_bubble, int_push} = 4'b1111;
                state_n = ST_JUMP;
            end
            default: begin
                {int_jump, int_ack, ifid_flush, idex_bubble} = 4'b1111;
                state_n = ST_RUN;
            end
        endcase
        if (reset) begin
            {pc_stall, ifid_stall, ifid_flush, idex_bubble} = 4'b0000;
            {int_push, int_jump, int_ack} = 3'b000;
        end
    end
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed scenarios plus random stimulus against a queue-based model
module tb_hazard_stall_controller;
    localparam int AW = 3;
    localparam int DC = 2;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset;
    logic [AW-1:0] id_src1_addr, id_src2_addr, ex_wr_addr, mem_wr_addr;
    logic id_src1_used, id_src2_used, ex_reg_write, ex_mem_read, mem_reg_write;
    logic branch_taken, int_req;
    logic pc_stall, ifid_stall, ifid_flush, idex_bubble, int_push, int_jump, int_ack;
    logic [CW-1:0] stall_count;
    logic [6:0] outs;

    int errs = 0;
    int checks = 0;

    localparam logic [6:0] O_IDLE  = 7'b0000000;
    localparam logic [6:0] O_STALL = 7'b1101000;
    localparam logic [6:0] O_FLUSH = 7'b0011000;
    localparam logic [6:0] O_PUSH  = 7'b1101100;
    localparam logic [6:0] O_JUMP  = 7'b0011011;

    assign outs = {pc_stall, ifid_stall, ifid_flush, idex_bubble, int_push, int_jump, int_ack};

    hazard_stall_controller #(.REG_ADDR_W(AW), .DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .id_src1_addr(id_src1_addr),
        .id_src2_addr(id_src2_addr),
        .id_src1_used(id_src1_used),
        .id_src2_used(id_src2_used),
        .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read),
        .ex_wr_addr(ex_wr_addr),
        .mem_reg_write(mem_reg_write),
        .mem_wr_addr(mem_wr_addr),
        .branch_taken(branch_taken),
        .int_req(int_req),
        .pc_stall(pc_stall),
        .ifid_stall(ifid_stall),
        .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble),
        .int_push(int_push),
        .int_jump(int_jump),
        .int_ack(int_ack),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        {id_src1_addr, id_src2_addr, ex_wr_addr, mem_wr_addr} = '0;
        {id_src1_used, id_src2_used, ex_reg_write, ex_mem_read, mem_reg_write} = '0;
        branch_taken = 1'b0;
        int_req = 1'b0;
    endtask

    task automatic load_use();
        ex_mem_read = 1'b1;
        ex_reg_write = 1'b1;
        ex_wr_addr = 3'd3;
        id_src2_addr = 3'd3;
        id_src2_used = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (outs !== O_IDLE) begin errs++; $display("FAIL reset_outs: got %b expected %b", outs, O_IDLE); end
        checks++;
        if (stall_count !== '0) begin errs++; $display("FAIL reset_count: got %0d expected 0", stall_count); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        @(negedge clk);
        clear_inputs();
        load_use();
        #2;
        checks++;
        if (outs !== O_STALL) begin errs++; $display("FAIL load_use_outs: got %b expected %b", outs, O_STALL); end
        checks++;
        if (stall_count !== 16'd0) begin errs++; $display("FAIL load_use_count0: got %0d expected 0", stall_count); end
        @(negedge clk);
        id_src2_used = 1'b0;
        #2;
        checks++;
        if (stall_count !== 16'd1) begin errs++; $display("FAIL load_use_count1: got %0d expected 1", stall_count); end
        checks++;
        if (outs !== O_IDLE) begin errs++; $display("FAIL unused_src_outs: got %b expected %b", outs, O_IDLE); end
        @(negedge clk);
        clear_inputs();
        #2;
        checks++;
        if (stall_count !== 16'd1) begin errs++; $display("FAIL unused_src_count: got %0d expected 1", stall_count); end
    endtask

    task automatic test_branch();
        logic [CW-1:0] c0;
        @(negedge clk);
        clear_inputs();
        load_use();
        branch_taken = 1'b1;
        c0 = stall_count;
        #2;
        checks++;
        if (outs !== O_FLUSH) begin errs++; $display("FAIL branch_outs: got %b expected %b", outs, O_FLUSH); end
        @(negedge clk);
        clear_inputs();
        #2;
        checks++;
        if (stall_count !== c0) begin errs++; $display("FAIL branch_count: got %0d expected %0d", stall_count, c0); end
    endtask

    task automatic test_interrupt();
        logic [6:0] exp_seq [5];
        logic [CW-1:0] c0;
        exp_seq = '{O_STALL, O_STALL, O_PUSH, O_JUMP, O_IDLE};
        c0 = stall_count;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clear_inputs();
            int_req = (i == 0);
            #2;
            checks++;
            if (outs !== exp_seq[i]) begin errs++; $display("FAIL interrupt_cycle%0d: got %b expected %b", i, outs, exp_seq[i]); end
        end
        checks++;
        if (stall_count !== c0 + 16'd3) begin errs++; $display("FAIL interrupt_count: got %0d expected %0d", stall_count, c0 + 16'd3); end
    endtask

    task automatic test_int_during_hazard();
        logic [6:0] exp_seq [6];
        int acks;
        exp_seq = '{O_STALL, O_STALL, O_STALL, O_PUSH, O_JUMP, O_IDLE};
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            clear_inputs();
            if (i == 0) begin load_use(); int_req = 1'b1; end
            #2;
            acks += int'(int_ack);
            if (i < 6) begin
                checks++;
                if (outs !== exp_seq[i]) begin errs++; $display("FAIL int_hazard_cycle%0d: got %b expected %b", i, outs, exp_seq[i]); end
            end
        end
        checks++;
        if (acks != 1) begin errs++; $display("FAIL int_hazard_acks: got %0d expected 1", acks); end
    endtask

    task automatic test_mem_hazard();
        logic [6:0] exp;
`ifdef HAZ_NO_FORWARD_EN
        exp = O_STALL;
`else
        exp = O_IDLE;
`endif
        @(negedge clk);
        clear_inputs();
        mem_reg_write = 1'b1;
        mem_wr_addr = 3'd5;
        id_src1_addr = 3'd5;
        id_src1_used = 1'b1;
        #2;
        checks++;
        if (outs !== exp) begin errs++; $display("FAIL mem_hazard: got %b expected %b", outs, exp); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_random();
        int q[$];
        bit pend;
        int cnt;
        bit hz_m, taken;
        logic [6:0] exp;
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q = {};
        pend = 1'b0;
        cnt = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            id_src1_addr = AW'($urandom_range(0, 7));
            id_src2_addr = AW'($urandom_range(0, 7));
            ex_wr_addr = AW'($urandom_range(0, 7));
            mem_wr_addr = AW'($urandom_range(0, 7));
            id_src1_used = 1'($urandom);
            id_src2_used = 1'($urandom);
            ex_reg_write = 1'($urandom);
            ex_mem_read = 1'($urandom);
            mem_reg_write = 1'($urandom);
            branch_taken = ($urandom_range(0, 7) == 0);
            int_req = ($urandom_range(0, 15) == 0);
`ifdef HAZ_NO_FORWARD_EN
            hz_m = (ex_reg_write && ((id_src1_used && id_src1_addr == ex_wr_addr) || (id_src2_used && id_src2_addr == ex_wr_addr)))
                || (mem_reg_write && ((id_src1_used && id_src1_addr == mem_wr_addr) || (id_src2_used && id_src2_addr == mem_wr_addr)));
`else
            hz_m = ex_mem_read && ex_reg_write && ((id_src1_used && id_src1_addr == ex_wr_addr) || (id_src2_used && id_src2_addr == ex_wr_addr));
`endif
            taken = 1'b0;
            if (q.size() > 0) exp = (q[0] == 0) ? O_STALL : (q[0] == 1) ? O_PUSH : O_JUMP;
            else if (branch_taken) exp = O_FLUSH;
            else if (hz_m) exp = O_STALL;
            else if (pend || int_req) begin exp = O_STALL; taken = 1'b1; end
            else exp = O_IDLE;
            #2;
            checks++;
            if (outs !== exp) begin errs++; $display("FAIL random_outs@%0d: got %b expected %b", n, outs, exp); end
            checks++;
            if (stall_count !== CW'(cnt)) begin errs++; $display("FAIL random_count@%0d: got %0d expected %0d", n, stall_count, cnt); end
            if (q.size() > 0) void'(q.pop_front());
            if (taken) begin
                pend = 1'b0;
                for (int k = 1; k < DC; k++) q.push_back(0);
                q.push_back(1);
                q.push_back(2);
            end else if (int_req) pend = 1'b1;
            if (exp[6] && cnt < 65535) cnt++;
        end
    endtask

    task automatic test_reset_mid();
        int acks;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clear_inputs();
            int_req = (i == 0);
        end
        #2;
        checks++;
        if (int_push !== 1'b1) begin errs++; $display("FAIL reset_mid_in_push: got %b expected 1", int_push); end
        reset = 1'b1;
        #1;
        checks++;
        if (outs !== O_IDLE) begin errs++; $display("FAIL reset_mid_outs: got %b expected %b", outs, O_IDLE); end
        checks++;
        if (stall_count !== '0) begin errs++; $display("FAIL reset_mid_count: got %0d expected 0", stall_count); end
        @(negedge clk);
        reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            acks += int'(int_ack);
            checks++;
            if (outs !== O_IDLE) begin errs++; $display("FAIL reset_mid_after%0d: got %b expected %b", i, outs, O_IDLE); end
        end
        checks++;
        if (acks != 0) begin errs++; $display("FAIL reset_mid_acks: got %0d expected 0", acks); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_interrupt();
        test_int_during_hazard();
        test_mem_hazard();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
